uart_word_tx: RTL and testbench

UART_WORD_TX -- requirements
Module: uart_word_tx

---
 rtl/uart_word_tx_if.sv | 24 ++
 rtl/uart_word_tx.sv | 159 +++++++++++++++
 tb/tb_uart_word_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_word_tx_if.sv
// Bundle of start/status and memory-port signals between a dump requester
// (master) and the uart_word_tx engine (slave).
interface uart_word_tx_if;
    logic        start;
    logic [7:0]  start_addr;
    logic [8:0]  num_words;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic        tx_serial;
    logic        busy;
    logic        done;

    // Requester side: issues start and serves the synchronous memory read port.
    modport master (
        output start, start_addr, num_words, mem_data,
        input  mem_addr, tx_serial, busy, done
    );

    // Engine side: consumes the request and drives address, line and status.
    modport slave (
        input  start, start_addr, num_words, mem_data,
        output mem_addr, tx_serial, busy, done
    );
endinterface

// File: rtl/uart_word_tx.sv
// Streams a block of 32-bit words from a synchronous-read memory out of a
// UART 8N1 line, little-endian byte order, LSB first within each byte.
// Per word: FETCH (present address), LOAD (capture data), then four
// back-to-back START/DATA/STOP frames. All outputs come straight from flops.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic    clk,
    input  logic    reset,
    uart_word_tx_if.slave bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP,
        FINISH
    } state_t;

    state_t           state;
    logic [7:0]       addr;        // address of the word being sent
    logic [8:0]       remaining;   // words still to send, including current
    logic [31:0]      shift_word;  // current word, shifted right one bit per data bit
    logic [CNT_W-1:0] bit_cnt;     // clock count within the current bit period
    logic [2:0]       bit_idx;     // data bit within the current byte
    logic [1:0]       byte_idx;    // byte within the current word
    logic             bit_end;

    // Last clock of the current bit period.
    assign bit_end = (bit_cnt == LAST_CNT);

    // Single FSM with registered outputs; the serial line never sees combinational logic.
    // NOTE: every state and output register uses <= so all of them update together
    // from the values sampled at this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            shift_word    <= '0;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            bus.mem_addr  <= '0;
            bus.tx_serial <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.tx_serial <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.done      <= 1'b0;
                    if (bus.start) begin
                        addr      <= bus.start_addr;
                        remaining <= bus.num_words;
                        if (bus.num_words != 9'd0) begin
                            state        <= FETCH;
                            bus.busy     <= 1'b1;
                            bus.mem_addr <= bus.start_addr;
                        end else begin
                            // Empty dump: report completion without ever going busy.
                            state    <= FINISH;
                            bus.done <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    // mem_addr was loaded on entry; memory answers next cycle.
                    state <= LOAD;
                end

                LOAD: begin
                    shift_word    <= bus.mem_data;
                    byte_idx      <= '0;
                    bit_cnt       <= '0;
                    state         <= START;
                    bus.tx_serial <= 1'b0;
                end

                START: begin
                    if (bit_end) begin
                        bit_cnt       <= '0;
                        bit_idx       <= '0;
                        state         <= DATA;
                        bus.tx_serial <= shift_word[0];
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        bit_cnt    <= '0;
                        // After eight shifts the next byte sits in bits [7:0].
                        shift_word <= shift_word >> 1;
                        if (bit_idx == 3'd7) begin
                            state         <= STOP;
                            bus.tx_serial <= 1'b1;
                        end else begin
                            bit_idx       <= bit_idx + 3'd1;
                            bus.tx_serial <= shift_word[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (byte_idx == 2'd3) begin
                            byte_idx  <= '0;
                            remaining <= remaining - 9'd1;
                            addr      <= addr + 8'd1;
                            if (remaining != 9'd1) begin
                                // Line stays high through FETCH and LOAD of the next word.
                                state        <= FETCH;
                                bus.mem_addr <= addr + 8'd1;
                            end else begin
                                state    <= FINISH;
                                bus.busy <= 1'b0;
                                bus.done <= 1'b1;
                            end
                        end else begin
                            byte_idx      <= byte_idx + 2'd1;
                            state         <= START;
                            bus.tx_serial <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                FINISH: begin
                    bus.done      <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.tx_serial <= 1'b1;
                    state         <= IDLE;
                end

                default: begin
                    state         <= IDLE;
                    bus.tx_serial <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx at 4 clocks per bit: a synchronous-read
// memory model, a cycle-exact UART receiver and hand-placed checkpoints.
module tb_uart_word_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset;
    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;
    int done_pulses = 0;

    uart_word_tx_if bus ();

    uart_word_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

    // Count every cycle in which done is high.
    always @(posedge clk) if (bus.done === 1'b1) done_pulses <= done_pulses + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on the first cycle of a start bit; samples every cycle of all ten
    // bits and returns on the first cycle after the stop bit.
    task automatic rx_byte(output logic [7:0] b, output logic ok);
        logic v;
        ok = 1'b1;
        b  = '0;
        for (int k = 0; k < 10; k++) begin
            v = bus.tx_serial;
            for (int c = 0; c < CPB; c++) begin
                if (bus.tx_serial !== v) ok = 1'b0;
                @(negedge clk);
            end
            if (k == 0 && v !== 1'b0) ok = 1'b0;
            if (k == 9 && v !== 1'b1) ok = 1'b0;
            if (k >= 1 && k <= 8) b[k-1] = v;
        end
    endtask

    // Full dump with exact-cycle expectations. With poke set, a second start
    // (addr 0x55, 3 words) is raised while the first word is loading.
    task automatic run_dump(input logic [7:0] sa, input logic [8:0] n, input bit poke);
        int d0;
        logic [7:0] a;
        logic [7:0] b;
        logic ok;
        d0 = done_pulses;
        bus.start      = 1'b1;
        bus.start_addr = sa;
        bus.num_words  = n;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, (n != 9'd0));
        a = sa;
        for (int w = 0; w < int'(n); w++) begin
            check("fetch_addr", bus.mem_addr, a);
            check("fetch_tx_high", bus.tx_serial, 1'b1);
            check("fetch_busy", bus.busy, 1'b1);
            @(negedge clk);
            check("load_tx_high", bus.tx_serial, 1'b1);
            if (poke && w == 0) begin
                bus.start      = 1'b1;
                bus.start_addr = 8'h55;
                bus.num_words  = 9'd3;
            end
            @(negedge clk);
            bus.start = 1'b0;
            for (int k = 0; k < 4; k++) begin
                rx_byte(b, ok);
                check("byte_frame_data", {ok, b}, {1'b1, mem[a][8*k +: 8]});
            end
            a = a + 8'd1;
        end
        check("finish_done", bus.done, 1'b1);
        check("finish_busy", bus.busy, 1'b0);
        check("finish_tx_high", bus.tx_serial, 1'b1);
        if (n != 9'd0) check("addr_hold", bus.mem_addr, a - 8'd1);
        @(negedge clk);
        check("done_once", done_pulses - d0, 1);
        check("idle_done_low", bus.done, 1'b0);
        check("idle_busy_low", bus.busy, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        logic ok;
        int d0;

        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            mem[i] = {iv * 8'd3 + 8'd1, ~iv, iv ^ 8'hA5, iv + 8'h10};
        end
        mem[0]     = 32'h1234_5678;
        mem[2]     = 32'h0000_C3A5;
        mem[8'hFF] = 32'hA5C3_0F01;

        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.num_words  = '0;
        reset          = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", bus.tx_serial, 1'b1);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_mem_addr", bus.mem_addr, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // One word: 0x78 0x56 0x34 0x12, then start accepted right after done.
        run_dump(8'h00, 9'd1, 1'b0);

        // Empty dump: done on the next cycle, never busy.
        run_dump(8'h10, 9'd0, 1'b0);

        // Address wrap 0xFF -> 0x00 with the inter-word gap.
        run_dump(8'hFF, 9'd2, 1'b0);

        // Start raised mid-dump must not disturb anything.
        run_dump(8'h00, 9'd1, 1'b1);

        // Reset while byte 2 of word 2 (data 0x00) is in its data bits.
        bus.start      = 1'b1;
        bus.start_addr = 8'h02;
        bus.num_words  = 9'd1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rx_byte(b, ok);
        check("abort_byte0", {ok, b}, {1'b1, 8'hA5});
        rx_byte(b, ok);
        check("abort_byte1", {ok, b}, {1'b1, 8'hC3});
        repeat (CPB + 2) @(negedge clk);
        check("abort_pre_tx_low", bus.tx_serial, 1'b0);
        d0 = done_pulses;
        reset = 1'b1;
        @(negedge clk);
        check("abort_tx_high", bus.tx_serial, 1'b1);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_mem_addr", bus.mem_addr, 8'h00);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", done_pulses - d0, 0);
        check("abort_line_idle", bus.tx_serial, 1'b1);
        run_dump(8'h00, 9'd1, 1'b0);

        // Reset wins over start in the same cycle.
        reset          = 1'b1;
        bus.start      = 1'b1;
        bus.start_addr = 8'h07;
        bus.num_words  = 9'd5;
        @(negedge clk);
        check("prio_busy", bus.busy, 1'b0);
        check("prio_mem_addr", bus.mem_addr, 8'h00);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("prio_still_idle", bus.busy, 1'b0);

        // Full 256-word dump wrapping through every address.
        run_dump(8'h80, 9'd256, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
